// File: rtl/register_file_2r1w_if.sv
// Register file access bundle: one write port, two read ports,
// plus the decoded write enables for visibility.
interface register_file_2r1w_if;
   logic        reg_write;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddr_a;
   logic [4:0]  raddr_b;
   logic [31:0] rdata_a;
   logic [31:0] rdata_b;
   logic [31:0] wr_onehot;

   modport master (
      output reg_write,
      output waddr,
      output wdata,
      output raddr_a,
      output raddr_b,
      input  rdata_a,
      input  rdata_b,
      input  wr_onehot
   );

   modport slave (
      input  reg_write,
      input  waddr,
      input  wdata,
      input  raddr_a,
      input  raddr_b,
      output rdata_a,
      output rdata_b,
      output wr_onehot
   );
endinterface

// File: rtl/register_file_2r1w.sv
// 32 x 32-bit MIPS register file, one decoded write port and two
// 32:1 read selectors; r0 has no storage and always reads zero.
module register_file_2r1w #(
   parameter bit WRITE_THROUGH = 1'b1
) (
   input  logic                clk,
   input  logic                reset_n,
   register_file_2r1w_if.slave bus
);

   logic [31:0] regs [1:31];
   logic [31:0] wr_onehot;
   logic [31:0] stored_a;
   logic [31:0] stored_b;
   logic        bypass_a;
   logic        bypass_b;

   // Bit 0 is never set, so writes to $zero vanish here.
   always_comb begin
      wr_onehot = '0;
      for (int i = 1; i < 32; i++) begin
         wr_onehot[i] = bus.reg_write && (bus.waddr == 5'(i));
      end
   end

   assign bus.wr_onehot = wr_onehot;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 1; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int i = 1; i < 32; i++) begin
            if (wr_onehot[i]) begin
               regs[i] <= bus.wdata;
            end
         end
      end
   end

   always_comb begin
      stored_a = '0;
      stored_b = '0;
      for (int i = 1; i < 32; i++) begin
         if (bus.raddr_a == 5'(i)) begin
            stored_a = regs[i];
         end
         if (bus.raddr_b == 5'(i)) begin
            stored_b = regs[i];
         end
      end
   end

   assign bypass_a = WRITE_THROUGH && wr_onehot[bus.raddr_a];
   assign bypass_b = WRITE_THROUGH && wr_onehot[bus.raddr_b];

   // Reset masks the reads too, so a pending bypass cannot leak out.
   always_comb begin
      bus.rdata_a = '0;
      bus.rdata_b = '0;
      if (reset_n) begin
         bus.rdata_a = bypass_a ? bus.wdata : stored_a;
         bus.rdata_b = bypass_b ? bus.wdata : stored_b;
      end
   end

endmodule

// File: tb/tb_register_file_2r1w.sv
// Directed and random checks of both write-through variants
// against an array model of the architectural registers.
module tb_register_file_2r1w;

   logic        clk;
   logic        reset_n;
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic [4:0]  ra;
   logic [4:0]  rb;
   logic [31:0] model [32];
   int          n_cmp;
   int          n_err;

   register_file_2r1w_if b1 ();
   register_file_2r1w_if b0 ();

   assign b1.reg_write = we;
   assign b1.waddr     = wa;
   assign b1.wdata     = wd;
   assign b1.raddr_a   = ra;
   assign b1.raddr_b   = rb;
   assign b0.reg_write = we;
   assign b0.waddr     = wa;
   assign b0.wdata     = wd;
   assign b0.raddr_a   = ra;
   assign b0.raddr_b   = rb;

   register_file_2r1w #(.WRITE_THROUGH(1'b1)) dut_wt (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (b1)
   );

   register_file_2r1w #(.WRITE_THROUGH(1'b0)) dut_nwt (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (b0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_read(bit wt, logic [4:0] a);
      if (!reset_n || a == 5'd0) return 32'h0;
      if (wt && we && wa == a) return wd;
      return model[a];
   endfunction

   function automatic logic [31:0] exp_onehot();
      logic [31:0] one;
      one = 32'h1;
      if (we && wa != 5'd0) return one << wa;
      return 32'h0;
   endfunction

   task automatic check_all(string tag);
      chk({tag, ".oh_wt"}, b1.wr_onehot, exp_onehot());
      chk({tag, ".oh_nwt"}, b0.wr_onehot, exp_onehot());
      chk({tag, ".a_wt"}, b1.rdata_a, exp_read(1'b1, ra));
      chk({tag, ".b_wt"}, b1.rdata_b, exp_read(1'b1, rb));
      chk({tag, ".a_nwt"}, b0.rdata_a, exp_read(1'b0, ra));
      chk({tag, ".b_nwt"}, b0.rdata_b, exp_read(1'b0, rb));
   endtask

   // One clock: drive after negedge, check before posedge, commit.
   task automatic cyc(string tag, logic w, logic [4:0] waddr,
                      logic [31:0] wdata, logic [4:0] a, logic [4:0] b);
      @(negedge clk);
      we = w;
      wa = waddr;
      wd = wdata;
      ra = a;
      rb = b;
      #1;
      check_all(tag);
      @(posedge clk);
      if (reset_n && we && wa != 5'd0) model[wa] = wd;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      reset_n = 1'b0;
      we = 1'b1;
      wa = 5'd3;
      wd = 32'h5555_AAAA;
      ra = 5'd3;
      rb = 5'd0;
      #2;
      check_all("rst0");
      @(negedge clk);
      reset_n = 1'b1;

      cyc("r5w", 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd1);
      cyc("r5rd", 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);

      @(negedge clk);
      we = 1'b1;
      wa = 5'd5;
      wd = 32'h0BAD_F00D;
      ra = 5'd5;
      rb = 5'd5;
      #2;
      reset_n = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      #1;
      check_all("rst_async");
      @(posedge clk);
      @(negedge clk);
      we = 1'b0;
      reset_n = 1'b1;
      #1;
      check_all("rst_rel");
      cyc("rst_hold", 1'b0, 5'd5, 32'h1, 5'd5, 5'd9);

      cyc("w1", 1'b1, 5'd1, 32'h0000_0011, 5'd2, 5'd3);
      cyc("w31", 1'b1, 5'd31, 32'hFFFF_FFFF, 5'd1, 5'd0);
      cyc("rd1_31", 1'b0, 5'd0, 32'h0, 5'd1, 5'd31);

      cyc("zero_w", 1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd1);
      for (int i = 0; i < 32; i++) begin
         cyc("zero_chk", 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      end

      cyc("r7w", 1'b1, 5'd7, 32'h0000_0001, 5'd6, 5'd8);
      cyc("byp", 1'b1, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd7);
      cyc("byp_aft", 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);

      for (int i = 0; i < 32; i++) begin
         cyc("hold", 1'b0, 5'(i), $urandom, 5'(i), 5'(31 - i));
      end

      for (int i = 1; i < 32; i++) begin
         cyc("sweep_w", 1'b1, 5'(i), i * 32'h0101_0101, 5'(i), 5'(32 - i));
      end
      for (int i = 1; i < 32; i++) begin
         cyc("sweep_r", 1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i));
      end

      cyc("b2b_1", 1'b1, 5'd12, 32'h1111_1111, 5'd12, 5'd0);
      cyc("b2b_2", 1'b1, 5'd12, 32'h2222_2222, 5'd12, 5'd12);
      cyc("b2b_r", 1'b0, 5'd12, 32'h0, 5'd12, 5'd12);

      for (int n = 0; n < 400; n++) begin
         cyc("rand", 1'($urandom), 5'($urandom), $urandom,
             5'($urandom), 5'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
